// File: rtl/find_inv_bvmul_seq.sv
// Sequential solver for the smallest unsigned x with (x*s mod 2^W) OP t.
// One candidate per cycle; the product is accumulated by repeated addition of s.
module find_inv_bvmul_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         found
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [W:0] CAND_LAST = {1'b0, {W{1'b1}}};

    state_t         state_q, state_d;
    logic [W-1:0]   s_q, s_d;
    logic [W-1:0]   t_q, t_d;
    logic [1:0]     mode_q, mode_d;
    logic [W:0]     cand_q, cand_d;
    logic [W-1:0]   prod_q, prod_d;
    logic [W-1:0]   x_q, x_d;
    logic           found_q, found_d;
    logic           pred;
    logic           last;

    always_comb begin
        pred = 1'b0;
        case (mode_q)
            2'b00:   pred = (prod_q < t_q);
            2'b01:   pred = (prod_q > t_q);
            2'b10:   pred = (prod_q == t_q);
            default: pred = ($signed(prod_q) < $signed(t_q));
        endcase
    end

    assign last = (cand_q == CAND_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SEARCH;
            SEARCH:  if (pred || last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath: operands latch on accept, candidate/product advance while searching.
    always_comb begin
        s_d     = s_q;
        t_d     = t_q;
        mode_d  = mode_q;
        cand_d  = cand_q;
        prod_d  = prod_q;
        x_d     = x_q;
        found_d = found_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d    = s;
                    t_d    = t;
                    mode_d = mode;
                    cand_d = '0;
                    prod_d = '0;
                end
            end
            SEARCH: begin
                if (pred) begin
                    x_d     = cand_q[W-1:0];
                    found_d = 1'b1;
                end else if (last) begin
                    x_d     = '0;
                    found_d = 1'b0;
                end else begin
                    cand_d = cand_q + (W+1)'(1);
                    prod_d = prod_q + s_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            t_q     <= '0;
            mode_q  <= '0;
            cand_q  <= '0;
            prod_q  <= '0;
            x_q     <= '0;
            found_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            t_q     <= t_d;
            mode_q  <= mode_d;
            cand_q  <= cand_d;
            prod_q  <= prod_d;
            x_q     <= x_d;
            found_q <= found_d;
        end
    end

    assign x     = x_q;
    assign found = found_q;

endmodule

// File: tb/tb_find_inv_bvmul_seq.sv
// Scoreboard bench for find_inv_bvmul_seq at W=4 and W=8.
module tb_find_inv_bvmul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 0, found4;
    logic [3:0] s4 = 0, t4 = 0, x4;
    logic [1:0] mode4 = 0;

    logic       in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0, found8;
    logic [7:0] s8 = 0, t8 = 0, x8;
    logic [1:0] mode8 = 0;

    find_inv_bvmul_seq #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .s(s4), .t(t4), .mode(mode4), .out_valid(out_valid4),
        .out_ready(out_ready4), .x(x4), .found(found4)
    );

    find_inv_bvmul_seq #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .s(s8), .t(t8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .x(x8), .found(found8)
    );

    typedef struct {
        int x;
        int found;
        int lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   k_cyc  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: brute force with a true multiply, scanning x upward.
    function automatic exp_t model(input int w, input int s, input int t, input int mode);
        exp_t r;
        int   mask = (1 << w) - 1;
        r.x = 0; r.found = 0; r.lat = 1 << w;
        for (int c = 0; c <= mask; c++) begin
            int  p  = (c * s) & mask;
            int  ps = p;
            int  ts = t;
            bit  ok;
            if (p >= (1 << (w - 1))) ps = p - (1 << w);
            if (t >= (1 << (w - 1))) ts = t - (1 << w);
            case (mode)
                0: ok = (p < t);
                1: ok = (p > t);
                2: ok = (p == t);
                default: ok = (ps < ts);
            endcase
            if (ok) begin
                r.x = c; r.found = 1; r.lat = 1 + c;
                break;
            end
        end
        return r;
    endfunction

    function automatic bit ov(input int w);
        return (w == 4) ? out_valid4 : out_valid8;
    endfunction
    function automatic bit ir(input int w);
        return (w == 4) ? in_ready4 : in_ready8;
    endfunction
    function automatic int xo(input int w);
        return (w == 4) ? int'(x4) : int'(x8);
    endfunction
    function automatic int fo(input int w);
        return (w == 4) ? int'(found4) : int'(found8);
    endfunction

    task automatic drive(input int w, input bit v, input int s, input int t, input int mode);
        if (w == 4) begin
            in_valid4 = v; s4 = 4'(s); t4 = 4'(t); mode4 = 2'(mode);
        end else begin
            in_valid8 = v; s8 = 8'(s); t8 = 8'(t); mode8 = 2'(mode);
        end
    endtask

    task automatic set_ready(input int w, input bit r);
        if (w == 4) out_ready4 = r;
        else out_ready8 = r;
    endtask

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic start_req(input int w, input int s, input int t, input int mode);
        check($sformatf("in_ready_before_w%0d", w), ir(w), 1);
        drive(w, 1'b1, s, t, mode);
        sbq.push_back(model(w, s, t, mode));
        @(posedge clk);
        @(negedge clk);
        k_cyc = cyc;
        drive(w, 1'b0, 0, 0, 0);
    endtask

    task automatic finish_req(input int w, input string tag, input int bp);
        exp_t e;
        int   n = 0;
        int   bound = (1 << w) + 8;
        while (!ov(w) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!ov(w)) begin
            check({tag, "_timeout"}, 0, 1);
            if (sbq.size() > 0) void'(sbq.pop_front());
            return;
        end
        e = sbq.pop_front();
        check({tag, "_lat"}, cyc - k_cyc, e.lat);
        check({tag, "_x"}, xo(w), e.x);
        check({tag, "_found"}, fo(w), e.found);
        for (int i = 0; i < bp; i++) begin
            drive(w, 1'b1, 1, 15, 0);
            @(negedge clk);
            check({tag, "_bp_valid"}, ov(w), 1);
            check({tag, "_bp_in_ready"}, ir(w), 0);
            check({tag, "_bp_x"}, xo(w), e.x);
            check({tag, "_bp_found"}, fo(w), e.found);
        end
        drive(w, 1'b0, 0, 0, 0);
        set_ready(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(w, 1'b0);
        check({tag, "_post_valid"}, ov(w), 0);
        check({tag, "_post_in_ready"}, ir(w), 1);
    endtask

    task automatic run_case(input int w, input string tag, input int s, input int t,
                            input int mode, input int bp);
        start_req(w, s, t, mode);
        finish_req(w, tag, bp);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ov4"}, out_valid4, 0);
        check({tag, "_ir4"}, in_ready4, 1);
        check({tag, "_x4"}, x4, 0);
        check({tag, "_f4"}, found4, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        reset_checks("reset");
        check("reset_ov8", out_valid8, 0);
        check("reset_ir8", in_ready8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_case(4, "ult_s3_t5", 3, 5, 0, 0);
        run_case(4, "ult_t0", 9, 0, 0, 0);
        run_case(4, "eq_s3_t5", 3, 5, 2, 0);
        run_case(4, "eq_s2_t5", 2, 5, 2, 0);
        run_case(4, "ugt_s5_t13", 5, 13, 1, 0);
        run_case(4, "ugt_s4_t13", 4, 13, 1, 0);
        run_case(4, "slt_s1_t0", 1, 0, 3, 0);
        run_case(4, "slt_s3_t9", 3, 9, 3, 0);
        run_case(4, "bp_eq", 3, 5, 2, 5);
        check("bp_queue_empty", sbq.size(), 0);

        // Abort while searching.
        start_req(4, 7, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_search");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(4, "recover", 5, 13, 1, 0);

        // Abort while holding a result.
        start_req(4, 3, 5, 2);
        repeat (12) @(negedge clk);
        check("rst_done_pre_ov", out_valid4, 1);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_done");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(4, "recover2", 3, 5, 2, 0);

        for (int i = 0; i < 6; i++) begin
            run_case(4, $sformatf("rand4_%0d", i), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 3), 0);
        end

        run_case(8, "w8_eq_s255_t1", 255, 1, 2, 0);
        run_case(8, "w8_slt_s1_t0", 1, 0, 3, 2);
        run_case(8, "w8_ult_t0", 17, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/find_inv_bvmul_seq.md
# find_inv_bvmul_seq

Parametrised, sequential invertibility solver for bit-vector multiplication constraints. For operands `s` and `t` of width `W` and a selected comparison, it searches for the smallest unsigned `x` such that `(x*s mod 2^W) OP t` holds. It reports `x` and a `found` flag; when no such `x` exists, it returns `x = 0` with `found = 0`. The block generalises the fixed 4-bit unsigned-less-than Skolem netlists to any width and four operators. It sits behind a valid/ready request port and in front of a valid/ready result port in the Skolem-evaluation datapath.

## Interface
- `W`, default 4: operand and result width; legal range 2..16.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  block can accept a request; high only in IDLE.
- `s`  input  W  multiplicand; sampled on the accept edge.
- `t`  input  W  comparison bound; sampled on the accept edge.
- `mode`  input  2  operator: 00 ULT (`x*s <u t`), 01 UGT (`>u`), 10 EQ (`==`), 11 SLT (signed `<`, two's complement, W bits); sampled on the accept edge.
- `out_valid`  output  1  result valid; high only in DONE.
- `out_ready`  input  1  consumer accepts the result.
- `x`  output  W  solution, or 0 if none exists.
- `found`  output  1  1 if `x` satisfies the constraint.

## Operation
- The FSM has three states: IDLE, SEARCH, DONE. Its registers are `s_q`, `t_q`, `mode_q`, `cand` (W+1 bits), `prod` (W bits), `x`, and `found`.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, latch `s`, `t`, `mode`; set `cand=0`, `prod=0`; go to SEARCH.
- SEARCH, one candidate per cycle:
  - Evaluate `pred(prod, t_q, mode_q)`, where `prod` always equals `cand*s_q mod 2^W`.
  - If `pred` is true: `x<=cand[W-1:0]`, `found<=1`, go to DONE.
  - Else if `cand==2^W-1`: `x<=0`, `found<=0`, go to DONE.
  - Else: `cand<=cand+1`, `prod<=prod+s_q` (truncated to W bits).
  - No multiplier is instantiated; the product is accumulated incrementally.
- DONE:
  - `out_valid=1`; `x` and `found` are held stable.
  - On `out_ready`, go to IDLE.
  - Results are never dropped; backpressure of any length is legal.
- Arithmetic rules:
  - All arithmetic is modulo 2^W.
  - ULT, UGT and EQ compare unsigned.
  - SLT compares `prod` and `t_q` as signed W-bit values.
- The result is always the minimal satisfying `x` in unsigned order.
- `in_valid` while not in IDLE is ignored (`in_ready=0`); the request must be held until accepted.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `x=0`, `found=0`, and internal registers 0.
- Reset mid-SEARCH or mid-DONE aborts immediately. The pending result is discarded and `out_valid` drops asynchronously.
- Let the accept edge be edge k:
  - Candidate c is evaluated in the cycle after edge k+c.
  - `out_valid` rises after edge k+1+c.
- Latency bounds:
  - Best case (c=0): `out_valid` rises after edge k+1.
  - No solution: 2^W evaluations, so `out_valid` rises after edge k+2^W.
- Same-cycle rules:
  - A DONE handshake (`out_valid & out_ready`) returns to IDLE at that edge.
  - `in_ready` rises the following cycle; there is no same-cycle pass-through.
- Outputs `in_ready` and `out_valid` are decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- W=4, ULT, s=3, t=5 -> `x=0`, `found=1`, `out_valid` one cycle after accept.
- W=4, ULT, t=0 (any s) -> `x=0`, `found=0` after 16 evaluations; `out_valid` rises after edge k+16.
- W=4, EQ, s=3, t=5 -> `x=7`, `found=1` (21 mod 16 = 5), `out_valid` after edge k+8.
- W=4, EQ, s=2, t=5 -> `found=0`, `x=0`.
- W=4, UGT, s=5, t=13 -> `x=3` (product 15).
- W=4, UGT, s=4, t=13 -> `found=0`.
- W=4, SLT, s=1, t=0 -> `x=8` (-8 < 0).
- Backpressure: hold `out_ready=0` for 5 cycles -> `x` and `found` stable, `in_ready=0`, a new `in_valid` is ignored.
- Reset: assert `rst_n=0` during SEARCH -> all outputs return to reset values.
- Recovery: the next request is accepted and solved correctly.
- W=8, EQ, s=255, t=1 -> `x=255`, `found=1`.
